// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: one-word holding buffer feeding an N-bit shift register.
// First bit appears one enabled edge after load; pin_ready drops while the holding buffer is full.
module piso_serializer #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] pin,
    input  logic         pin_valid,
    output logic         pin_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         frame_start,
    output logic         frame_end,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   hold_q, hold_d;
    logic           hold_full_q, hold_full_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        // Accept and load are mutually exclusive: one needs the buffer empty, the other full.
        if (pin_valid && !hold_full_q) begin
            hold_d      = pin;
            hold_full_d = 1'b1;
        end

        if (en) begin
            if (hold_full_q && (state_q == IDLE || cnt_q == CNT_LAST)) begin
                shreg_d     = hold_q;
                cnt_d       = '0;
                hold_full_d = 1'b0;
                state_d     = SHIFT;
            end else if (state_q == SHIFT) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (MSB_FIRST) shreg_d = {shreg_q[N-2:0], 1'b0};
                    else           shreg_d = {1'b0, shreg_q[N-1:1]};
                end
            end
        end
    end

    assign pin_ready   = ~hold_full_q;
    assign sout_valid  = (state_q == SHIFT);
    assign sout        = MSB_FIRST ? shreg_q[N-1] : shreg_q[0];
    assign frame_start = sout_valid && (cnt_q == '0);
    assign frame_end   = sout_valid && (cnt_q == CNT_LAST);
    assign busy        = sout_valid | hold_full_q;

endmodule
